// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed divider.
package div_pkg;

   localparam int WIDTH     = 32;
   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract |b|.
module div_step
   import div_pkg::*;
(
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] b_abs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0]   rem_sh;
   logic [WIDTH-1:0] trial;

   // rem_sh can reach 2*|b|-1, so the compare needs the extra bit; the
   // difference always fits WIDTH bits when it is kept.
   always_comb begin
      rem_sh = {rem_i, quo_i[WIDTH-1]};
      trial  = rem_sh[WIDTH-1:0] - b_abs_i;
      if (rem_sh >= {1'b0, b_abs_i}) begin
         rem_o = trial;
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = rem_sh[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// Sequential signed 32-bit divider (MIPS div semantics), 33 edges start-to-done.
// Optional divide-by-zero exception pulse: build with DIV_ZERO_EXCP_EN defined.
//
// state | meaning
// IDLE  | waiting for start; operands captured on start
// ITER  | one restoring step per cycle, DIV_ITERS cycles
// FIX   | apply signs, register hi/lo, pulse done
module div_unit
   import div_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

`ifdef DIV_ZERO_EXCP_EN
   localparam bit ZeroTrapEn = 1'b1;
`else
   localparam bit ZeroTrapEn = 1'b0;
`endif

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, quo_q, b_abs_q;
   logic [WIDTH-1:0] rem_d, quo_d;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             sign_q_q, sign_r_q;
   logic             busy_q, done_q, div_zero_q;
   logic             zero_trap;

   assign zero_trap = ZeroTrapEn && (b == '0);

   div_step u_step (
      .rem_i   (rem_q),
      .quo_i   (quo_q),
      .b_abs_i (b_abs_q),
      .rem_o   (rem_d),
      .quo_o   (quo_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         b_abs_q    <= '0;
         sign_q_q   <= 1'b0;
         sign_r_q   <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && zero_trap) begin
                  div_zero_q <= 1'b1;
               end else if (start) begin
                  quo_q    <= abs_val(a);
                  b_abs_q  <= abs_val(b);
                  rem_q    <= '0;
                  sign_q_q <= a[WIDTH-1] ^ b[WIDTH-1];
                  sign_r_q <= a[WIDTH-1];
                  cnt_q    <= CNT_W'(DIV_ITERS);
                  busy_q   <= 1'b1;
                  state_q  <= ITER;
               end
            end
            ITER: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_q <= FIX;
            end
            FIX: begin
               lo_q    <= sign_q_q ? (~quo_q + 1'b1) : quo_q;
               hi_q    <= sign_r_q ? (~rem_q + 1'b1) : rem_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, corner sequences, random vs. model.
module tb_div_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a, b;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int n_tests = 0;
   int n_fail  = 0;

   div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .hi       (hi),
      .lo       (lo),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Signed division in 64-bit arithmetic, truncated back to 32 bits.
   function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] h, output logic [31:0] l);
      longint sx, sy;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (sy == 0) begin
         h = x;
         l = (sx < 0) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      end else begin
         l = 32'(sx / sy);
         h = 32'(sx % sy);
      end
   endfunction

   // Drive a one-cycle start; returns #1 after the sampling edge (E0).
   task automatic pulse_start(input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      a     = x;
      b     = y;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Count edges after E0 until done is seen; returns #1 after the done edge.
   task automatic wait_done(input string nm, output int lat);
      int bad;
      bad = 0;
      lat = 0;
      forever begin
         @(posedge clk);
         #1;
         lat++;
         if (done || lat >= 40) break;
         if (!busy || div_zero) bad++;
      end
      check({nm, "_busy_window"}, 32'(bad), 32'd0);
      check({nm, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      check({nm, "_dz_at_done"}, {31'd0, div_zero}, 32'd0);
   endtask

   task automatic run_check(input string nm, input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] eh, input logic [31:0] el);
      int lat;
      pulse_start(x, y);
      wait_done(nm, lat);
      check({nm, "_latency"}, 32'(lat), 32'd33);
      check({nm, "_hi"}, hi, eh);
      check({nm, "_lo"}, lo, el);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, extra_done;
      logic [31:0] eh, el, ra, rb;

      vecs[0] = '{32'd100,       32'd7,         32'd2,         32'd14};
      vecs[1] = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2};
      vecs[2] = '{32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2};
      vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[4] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14};
      vecs[5] = '{32'd0,         32'd5,         32'd0,         32'd0};
      vecs[6] = '{32'd7,         32'd100,       32'd7,         32'd0};
      vecs[7] = '{32'h7FFF_FFFF, 32'd1,         32'd0,         32'h7FFF_FFFF};

      reset = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;

      #12;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_flags", {29'd0, busy, done, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_flags", {29'd0, busy, done, div_zero}, 32'd0);

      for (int i = 0; i < 8; i++)
         run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

`ifdef DIV_ZERO_EXCP_EN
      // Prior result is INT_MAX/1: hi=0, lo=0x7FFFFFFF
      @(posedge clk);
      #1;
      pulse_start(32'd5, 32'd0);
      check("dz_pulse", {31'd0, div_zero}, 32'd1);
      check("dz_no_busy", {30'd0, busy, done}, 32'd0);
      @(posedge clk);
      #1;
      check("dz_pulse_clear", {29'd0, busy, done, div_zero}, 32'd0);
      check("dz_hi_kept", hi, 32'd0);
      check("dz_lo_kept", lo, 32'h7FFF_FFFF);
`else
      run_check("dz_pos", 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_check("dz_neg", 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1);
`endif

      // Start while busy at E5 is ignored and not queued.
      @(posedge clk);
      #1;
      pulse_start(32'd100, 32'd7);
      repeat (4) @(posedge clk);
      #1;
      pulse_start(32'hFFFF_FFCE, 32'd3);
      wait_done("ignore", lat);
      check("ignore_latency", 32'(lat), 32'd28);
      check("ignore_hi", hi, 32'd2);
      check("ignore_lo", lo, 32'd14);
      extra_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done || busy) extra_done++;
      end
      check("ignore_not_queued", 32'(extra_done), 32'd0);

      // Reset at E10 aborts and clears everything.
      pulse_start(32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      check("abort_flags", {29'd0, busy, done, div_zero}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_idle", {29'd0, busy, done, div_zero}, 32'd0);
      run_check("after_abort", 32'hFFFF_FC18, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FEB3);

      // Back-to-back: start held in the done cycle is accepted.
      @(posedge clk);
      #1;
      pulse_start(32'd100, 32'd7);
      wait_done("b2b_first", lat);
      check("b2b_first_latency", 32'(lat), 32'd33);
      check("b2b_first_done", {31'd0, done}, 32'd1);
      pulse_start(32'd1234567, 32'hFFFF_FF85);
      wait_done("b2b_second", lat);
      check("b2b_second_latency", 32'(lat), 32'd33);
      ref_div(32'd1234567, 32'hFFFF_FF85, eh, el);
      check("b2b_second_hi", hi, eh);
      check("b2b_second_lo", lo, el);

      for (int i = 0; i < 200; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(1, 20))
                                                    : -32'($urandom_range(1, 20));
            2:       rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'd1;
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         if (i % 50 == 7) ra = 32'h8000_0000;
`ifdef DIV_ZERO_EXCP_EN
         if (rb == 32'd0) rb = 32'd1;
`else
         if (i % 40 == 3) rb = 32'd0;
`endif
         ref_div(ra, rb, eh, el);
         run_check($sformatf("rnd%0d", i), ra, rb, eh, el);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
